// File: rtl/apa102_out.sv
// APA102 SPI transmitter: 32 zero bits, NUM_LEDS MSB-first words, 32 one bits on sck/sda.
// Packet takes (32*NUM_LEDS+64)*2*CLK_DIV cycles; start is ignored while busy, with no queueing.
module apa102_out #(
  parameter int NUM_LEDS  = 7,
  parameter int CLK_DIV   = 4,
  parameter bit FORCE_HDR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [32*NUM_LEDS-1:0]  data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    sck,
  output logic                    sda
);

  localparam int DATA_BITS = 32 * NUM_LEDS;
  localparam int TOTAL     = DATA_BITS + 64;
  localparam int CW        = $clog2(TOTAL);
  localparam int DVW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0]  LAST_START = CW'(31);
  localparam logic [CW-1:0]  LAST_DATA  = CW'(DATA_BITS + 31);
  localparam logic [CW-1:0]  LAST_STOP  = CW'(TOTAL - 1);
  localparam logic [DVW-1:0] DIV_LAST   = DVW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START_FRM, DATA_FRM, STOP_FRM} state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   latch_dat;
  logic [CW-1:0]          bit_cnt;
  logic [DVW-1:0]         div_cnt;

  // APA102 words must carry 3'b111 in the top bits to be recognised as LED data.
  always_comb begin
    latch_dat = data_in;
    if (FORCE_HDR) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        latch_dat[32*i+29 +: 3] = 3'b111;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      sda     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= latch_dat;
            state   <= START_FRM;
            busy    <= 1'b1;
            sck     <= 1'b0;
            sda     <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DVW'(1);
          end else begin
            div_cnt <= '0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              // End of a bit: sda moves to the next bit while sck drops low.
              sck     <= 1'b0;
              bit_cnt <= bit_cnt + CW'(1);
              case (state)
                START_FRM: begin
                  if (bit_cnt == LAST_START) begin
                    state <= DATA_FRM;
                    sda   <= shreg[DATA_BITS-1];
                    shreg <= shreg << 1;
                  end
                end
                DATA_FRM: begin
                  if (bit_cnt == LAST_DATA) begin
                    state <= STOP_FRM;
                    sda   <= 1'b1;
                  end else begin
                    sda   <= shreg[DATA_BITS-1];
                    shreg <= shreg << 1;
                  end
                end
                STOP_FRM: begin
                  if (bit_cnt == LAST_STOP) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    sda   <= 1'b0;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apa102_out.sv
// Bench for apa102_out: three instances (default, no header forcing, CLK_DIV=1) checked against a bit-list model.
module tb_apa102_out;
  localparam int N  = 7;
  localparam int W  = 32 * N;
  localparam int NB = W + 64;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic [W-1:0] data_in;
  logic busy0, done0, sck0, sda0;
  logic busy1, done1, sck1, sda1;
  logic busy2, done2, sck2, sda2;

  apa102_out #(.NUM_LEDS(N), .CLK_DIV(4), .FORCE_HDR(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data_in),
    .busy(busy0), .done(done0), .sck(sck0), .sda(sda0));
  apa102_out #(.NUM_LEDS(N), .CLK_DIV(4), .FORCE_HDR(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in),
    .busy(busy1), .done(done1), .sck(sck1), .sda(sda1));
  apa102_out #(.NUM_LEDS(N), .CLK_DIV(1), .FORCE_HDR(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data_in),
    .busy(busy2), .done(done2), .sck(sck2), .sda(sda2));

  always #5 clk = ~clk;

  logic [1:0] sel;
  logic m_busy, m_done, m_sck, m_sda;
  assign m_busy = (sel == 2'd0) ? busy0 : (sel == 2'd1) ? busy1 : busy2;
  assign m_done = (sel == 2'd0) ? done0 : (sel == 2'd1) ? done1 : done2;
  assign m_sck  = (sel == 2'd0) ? sck0  : (sel == 2'd1) ? sck1  : sck2;
  assign m_sda  = (sel == 2'd0) ? sda0  : (sel == 2'd1) ? sda1  : sda2;

  logic cap [NB+16];
  logic exp_bits [NB];
  int   cap_n, busy_cyc, done_cnt, viol;
  bit   timeout;
  logic end_sck, end_sda, nxt_busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] spec_data;

  // Expected wire bits: 32 zeros, each word MSB-first (header optionally forced), 32 ones.
  function automatic void build_exp(input logic [W-1:0] d, input bit fh);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) exp_bits[b] = 1'b0;
    for (int i = 0; i < N; i++) begin
      w = d[W-1-32*i -: 32];
      if (fh) w[31:29] = 3'b111;
      for (int k = 0; k < 32; k++) exp_bits[32+32*i+k] = w[31-k];
    end
    for (int b = 0; b < 32; b++) exp_bits[32+W+b] = 1'b1;
  endfunction

  function automatic int bit_errs();
    int e = 0;
    for (int i = 0; i < NB; i++) if (i >= cap_n || cap[i] !== exp_bits[i]) e++;
    return e;
  endfunction

  function automatic logic [31:0] cap_word(input int i);
    logic [31:0] w;
    for (int k = 0; k < 32; k++) w[31-k] = cap[32+32*i+k];
    return w;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < N; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // Samples the selected instance once per cycle on the falling clk edge.
  task automatic capture(input int limit);
    int t;
    logic psck, psda;
    cap_n = 0; busy_cyc = 0; done_cnt = 0; viol = 0; timeout = 1'b0;
    psck = 1'b0; psda = 1'b0; t = 0;
    while (!m_busy && t < limit) begin @(negedge clk); t++; end
    if (!m_busy) begin timeout = 1'b1; return; end
    while (m_busy && t < limit) begin
      busy_cyc++;
      if (m_sck && !psck && cap_n < NB + 16) begin cap[cap_n] = m_sda; cap_n++; end
      if (m_sck && psck && m_sda !== psda) viol++;
      if (m_done) done_cnt++;
      psck = m_sck; psda = m_sda;
      @(negedge clk); t++;
    end
    if (m_busy) timeout = 1'b1;
    if (m_done) done_cnt++;
    end_sck = m_sck; end_sda = m_sda;
    @(negedge clk);
    if (m_done) done_cnt++;
    nxt_busy = m_busy;
  endtask

  task automatic test_reset();
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; data_in = '0; sel = 2'd0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy0, done0, sck0, sda0, busy1, done1, sck1, sda1, busy2, done2, sck2, sda2} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_powerup: outputs %b expected all zero",
               {busy0, done0, sck0, sda0, busy1, done1, sck1, sda1, busy2, done2, sck2, sda2});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy0, done0, sck0, sda0} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: outputs %b expected 0000", {busy0, done0, sck0, sda0});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    sel = 2'd0;
    data_in = spec_data;
    build_exp(spec_data, 1'b1);
    pulse_start(0);
    data_in = rand_data();
    capture(3000);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: packet did not complete"); end
    n_checks++;
    if (busy_cyc !== 2304) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 2304", busy_cyc); end
    n_checks++;
    if (cap_n !== 288) begin n_fail++; $display("FAIL single_sck_edges: got %0d expected 288", cap_n); end
    n_checks++;
    if (bit_errs() !== 0) begin n_fail++; $display("FAIL single_bits: %0d bit errors expected 0", bit_errs()); end
    n_checks++;
    if (cap_word(0) !== 32'hFF112233) begin
      n_fail++; $display("FAIL single_word0: got %h expected ff112233", cap_word(0));
    end
    n_checks++;
    if (cap_word(6) !== 32'hE0AABBCC) begin
      n_fail++; $display("FAIL single_word6: got %h expected e0aabbcc", cap_word(6));
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done: %0d pulses expected 1", done_cnt); end
    n_checks++;
    if ({end_sck, end_sda, nxt_busy} !== 3'b000) begin
      n_fail++; $display("FAIL single_idle_after: sck/sda/busy %b expected 000", {end_sck, end_sda, nxt_busy});
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL single_sda_stable: %0d changes while sck high, expected 0", viol); end
  endtask

  task automatic test_header();
    logic [W-1:0] d;
    sel = 2'd0;
    data_in = '0;
    pulse_start(0);
    capture(3000);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cap_word(i) !== 32'hE0000000) begin
        n_fail++; $display("FAIL hdr_forced_word%0d: got %h expected e0000000", i, cap_word(i));
      end
    end
    sel = 2'd1;
    pulse_start(1);
    capture(3000);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cap_word(i) !== 32'h00000000) begin
        n_fail++; $display("FAIL hdr_plain_word%0d: got %h expected 00000000", i, cap_word(i));
      end
    end
    d = rand_data();
    data_in = d;
    build_exp(d, 1'b0);
    pulse_start(1);
    capture(3000);
    n_checks++;
    if (bit_errs() !== 0 || busy_cyc !== 2304) begin
      n_fail++; $display("FAIL hdr_plain_random: %0d bit errors, %0d busy cycles, expected 0 and 2304", bit_errs(), busy_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    sel = 2'd0;
    a = rand_data();
    b = rand_data();
    data_in = a;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    fork
      capture(3000);
      begin repeat (500) @(negedge clk); data_in = b; end
    join
    build_exp(a, 1'b1);
    n_checks++;
    if (bit_errs() !== 0 || busy_cyc !== 2304) begin
      n_fail++; $display("FAIL b2b_first: %0d bit errors, %0d busy cycles, expected 0 and 2304", bit_errs(), busy_cyc);
    end
    n_checks++;
    if (nxt_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: busy %b one cycle after done, expected 1", nxt_busy); end
    fork
      capture(3000);
      begin repeat (50) @(negedge clk); start0 = 1'b0; end
    join
    build_exp(b, 1'b1);
    n_checks++;
    if (bit_errs() !== 0 || busy_cyc !== 2304) begin
      n_fail++; $display("FAIL b2b_second: %0d bit errors, %0d busy cycles, expected 0 and 2304", bit_errs(), busy_cyc);
    end
    n_checks++;
    if (done_cnt !== 1 || nxt_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: done %0d busy_after %b, expected 1 and 0", done_cnt, nxt_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    int seen;
    sel = 2'd0;
    d = rand_data();
    data_in = d;
    pulse_start(0);
    repeat ((32 + 100) * 8 + 3) @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: busy %b expected 1", busy0); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy0, done0, sck0, sda0} !== 4'b0) begin
      n_fail++; $display("FAIL midrst_async: outputs %b expected 0000", {busy0, done0, sck0, sda0});
    end
    seen = 0;
    repeat (4) begin @(negedge clk); if (done0) seen++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (done0) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: %0d done pulses expected 0", seen); end
    d = rand_data();
    data_in = d;
    build_exp(d, 1'b1);
    pulse_start(0);
    capture(3000);
    n_checks++;
    if (bit_errs() !== 0 || busy_cyc !== 2304 || done_cnt !== 1) begin
      n_fail++; $display("FAIL midrst_recover: %0d bit errors, %0d busy cycles, %0d done, expected 0/2304/1",
                         bit_errs(), busy_cyc, done_cnt);
    end
  endtask

  task automatic test_clkdiv1();
    sel = 2'd2;
    data_in = spec_data;
    build_exp(spec_data, 1'b1);
    pulse_start(2);
    capture(1000);
    n_checks++;
    if (busy_cyc !== 576) begin n_fail++; $display("FAIL div1_busy_len: got %0d expected 576", busy_cyc); end
    n_checks++;
    if (cap_n !== 288) begin n_fail++; $display("FAIL div1_sck_edges: got %0d expected 288", cap_n); end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL div1_sda_stable: %0d changes while sck high, expected 0", viol); end
    n_checks++;
    if (bit_errs() !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL div1_bits: %0d bit errors, %0d done, expected 0 and 1", bit_errs(), done_cnt);
    end
  endtask

  task automatic test_random_packets();
    logic [W-1:0] d;
    for (int r = 0; r < 4; r++) begin
      sel = (r % 2 == 0) ? 2'd0 : 2'd2;
      d = rand_data();
      data_in = d;
      build_exp(d, 1'b1);
      pulse_start(sel);
      capture(3000);
      n_checks++;
      if (bit_errs() !== 0 || timeout !== 1'b0) begin
        n_fail++; $display("FAIL random_pkt%0d: %0d bit errors, timeout %b, expected 0 and 0", r, bit_errs(), timeout);
      end
    end
  endtask

  initial begin
    spec_data = {32'hFF112233, 32'h12345678, 32'hA5A5A5A5, 32'h00FF00FF,
                 32'h1F2E3D4C, 32'h80000001, 32'hE0AABBCC};
    test_reset();
    test_single_packet();
    test_header();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    test_random_packets();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
